irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 195 +++++++++++++++++++
 tb/tb_irq_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Vectored interrupt controller: synchronized sources, register bus, one-at-a-time service FSM.
// Optional feature macro: IRQ_CTRL_EDGE_EN (per-channel edge mode with W1C pending bits).
module irq_controller #(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0010,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               ce_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] eoi_o,
  output logic               irq_req_o,
  output logic [4:0]         irq_num_o,
  output logic [31:0]        irq_vec_o,
  input  logic               irq_ack_i,
  input  logic               eoi_i,
  input  logic               sel_i,
  input  logic [3:0]         addr_i,
  input  logic               we_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               ack_o
);

  typedef enum logic [1:0] {IDLE, REQUEST, IN_SERVICE, EOI_HOLD} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] eoi_q, eoi_d;
  logic               req_q, req_d;
  logic [4:0]         num_q, num_d;
  logic [31:0]        vec_q, vec_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_IRQ-1:0] mode_c;
  logic [NUM_IRQ-1:0] pending_c;
  logic [NUM_IRQ-1:0] active_c;
  logic [NUM_IRQ-1:0] num_mask_c;
  logic [NUM_IRQ-1:0] svc_clr_c;
  logic [NUM_IRQ-1:0] wdata_c;
  logic [4:0]         first_c;
  logic               en_cur_c;
  logic               access_c;
  logic               wr_c;
  logic               unused_ok_c;

  assign unused_ok_c = ^{data_i, addr_i[1:0]};

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] pend_edge_q, pend_edge_d;

  // Edge channels latch on the cycle the synced line rises; set beats any clear.
  always_comb begin
    mode_d      = mode_q;
    pend_edge_d = pend_edge_q & ~svc_clr_c;
    if (wr_c && addr_i[3:2] == 2'd2) mode_d = wdata_c;
    if (wr_c && addr_i[3:2] == 2'd1) pend_edge_d = pend_edge_d & ~wdata_c;
    pend_edge_d = pend_edge_d | (sync1_q & ~sync2_q & mode_q);
  end

  // Edge-mode state registers.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode_q      <= '0;
      pend_edge_q <= '0;
    end else if (ce_i) begin
      mode_q      <= mode_d;
      pend_edge_q <= pend_edge_d;
    end
  end

  assign mode_c    = mode_q;
  assign pending_c = (mode_q & pend_edge_q) | (~mode_q & sync2_q);
`else
  assign mode_c    = '0;
  assign pending_c = sync2_q;
`endif

  assign active_c = pending_c & en_q;
  assign access_c = sel_i & ~ack_q;
  assign wr_c     = access_c & we_i;
  assign wdata_c  = data_i[NUM_IRQ-1:0];

  // Lowest-index active channel, enable of the latched channel, and its one-hot mask.
  always_comb begin
    first_c    = '0;
    en_cur_c   = 1'b0;
    num_mask_c = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active_c[i]) first_c = 5'(i);
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (5'(i) == num_q) begin
        en_cur_c      = en_q[i];
        num_mask_c[i] = 1'b1;
      end
    end
  end

  // Register bus: single-cycle ack one cycle after select, reads captured with the ack.
  always_comb begin
    en_d    = en_q;
    ack_d   = access_c;
    rdata_d = rdata_q;
    if (wr_c && addr_i[3:2] == 2'd0) en_d = wdata_c;
    if (access_c) begin
      case (addr_i[3:2])
        2'd0:    rdata_d = 32'(en_q);
        2'd1:    rdata_d = 32'(pending_c);
        2'd2:    rdata_d = 32'(mode_c);
        default: rdata_d = {state_q != IDLE, 26'd0, num_q};
      endcase
    end
  end

  // Service FSM next-state and outputs.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    num_d     = num_q;
    vec_d     = vec_q;
    eoi_d     = eoi_q;
    svc_clr_c = '0;
    case (state_q)
      IDLE: begin
        if (|active_c) begin
          num_d   = first_c;
          vec_d   = VEC_BASE + 32'(first_c) * 32'(VEC_STRIDE);
          req_d   = 1'b1;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (irq_ack_i) begin
          req_d     = 1'b0;
          eoi_d     = eoi_q & ~num_mask_c;
          svc_clr_c = num_mask_c;
          state_d   = IN_SERVICE;
        end else if (!en_cur_c) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      IN_SERVICE: begin
        if (eoi_i) begin
          eoi_d   = eoi_q | num_mask_c;
          state_d = EOI_HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i)  state_q <= IDLE;
    else if (ce_i)   state_q <= state_d;
  end

  // Datapath, synchronizer and bus registers.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      en_q    <= '0;
      eoi_q   <= '1;
      req_q   <= 1'b0;
      num_q   <= '0;
      vec_q   <= VEC_BASE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else if (ce_i) begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      en_q    <= en_d;
      eoi_q   <= eoi_d;
      req_q   <= req_d;
      num_q   <= num_d;
      vec_q   <= vec_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign eoi_o     = eoi_q;
  assign irq_req_o = req_q;
  assign irq_num_o = num_q;
  assign irq_vec_o = vec_q;
  assign ack_o     = ack_q;
  assign data_o    = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (default parameters).
`timescale 1ns/1ps
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        ce_i;
  logic [7:0]  irq_i;
  logic [7:0]  eoi_o;
  logic        irq_req_o;
  logic [4:0]  irq_num_o;
  logic [31:0] irq_vec_o;
  logic        irq_ack_i;
  logic        eoi_i;
  logic        sel_i;
  logic [3:0]  addr_i;
  logic        we_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  int checks = 0;
  int errors = 0;

  irq_controller dut (
    .clk(clk), .reset_n_i(reset_n_i), .ce_i(ce_i), .irq_i(irq_i), .eoi_o(eoi_o),
    .irq_req_o(irq_req_o), .irq_num_o(irq_num_o), .irq_vec_o(irq_vec_o),
    .irq_ack_i(irq_ack_i), .eoi_i(eoi_i), .sel_i(sel_i), .addr_i(addr_i),
    .we_i(we_i), .data_i(data_i), .data_o(data_o), .ack_o(ack_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    step();
    checks++;
    if (ack_o !== 1'b1) begin
      errors++; $display("FAIL bus_write_ack addr=%h got=%b exp=1", a, ack_o);
    end
    sel_i = 1'b0; we_i = 1'b0;
    step();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    step();
    d = data_o;
    checks++;
    if (ack_o !== 1'b1) begin
      errors++; $display("FAIL bus_read_ack addr=%h got=%b exp=1", a, ack_o);
    end
    sel_i = 1'b0;
    step();
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (irq_req_o !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (irq_req_o !== 1'b1) begin
      errors++; $display("FAIL wait_req timeout got=%b exp=1", irq_req_o);
    end
  endtask

  task automatic do_ack(input logic [7:0] exp_eoi);
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
    checks++;
    if (irq_req_o !== 1'b0 || eoi_o !== exp_eoi) begin
      errors++; $display("FAIL ack req=%b eoi=%h exp req=0 eoi=%h", irq_req_o, eoi_o, exp_eoi);
    end
  endtask

  task automatic do_eoi();
    eoi_i = 1'b1;
    step();
    eoi_i = 1'b0;
    checks++;
    if (eoi_o !== 8'hFF) begin
      errors++; $display("FAIL eoi_release got=%h exp=ff", eoi_o);
    end
    step();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (irq_req_o !== 1'b0 || irq_num_o !== 5'd0 || irq_vec_o !== 32'h10 ||
        eoi_o !== 8'hFF || ack_o !== 1'b0 || data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs req=%b num=%0d vec=%h eoi=%h ack=%b data=%h exp 0,0,10,ff,0,0",
               irq_req_o, irq_num_o, irq_vec_o, eoi_o, ack_o, data_o);
    end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", d); end
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_enable got=%h exp=0", d); end
  endtask

  task automatic test_reg_width();
    logic [31:0] d;
    bus_write(4'h0, 32'hFFFF_FFFF);
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0000_00FF) begin errors++; $display("FAIL enable_width got=%h exp=ff", d); end
    bus_write(4'h0, 32'h0);
  endtask

  task automatic test_basic();
    logic [31:0] d;
    bus_write(4'h0, 32'h05);
    irq_i = 8'h04;
    step(); step();
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL basic_latency_early got=%b exp=0", irq_req_o); end
    step();
    checks++;
    if (irq_req_o !== 1'b1 || irq_num_o !== 5'd2 || irq_vec_o !== 32'h18 || eoi_o !== 8'hFF) begin
      errors++;
      $display("FAIL basic_req req=%b num=%0d vec=%h eoi=%h exp 1,2,18,ff", irq_req_o, irq_num_o, irq_vec_o, eoi_o);
    end
    do_ack(8'hFB);
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h8000_0002) begin errors++; $display("FAIL basic_status_busy got=%h exp=80000002", d); end
    irq_i = 8'h00;
    step(); step();
    do_eoi();
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h0000_0002 || irq_req_o !== 1'b0) begin
      errors++; $display("FAIL basic_status_idle status=%h req=%b exp 2,0", d, irq_req_o);
    end
    bus_write(4'h0, 32'h0);
  endtask

  task automatic test_priority();
    bus_write(4'h0, 32'hFF);
    irq_i = 8'h0A;
    wait_req(10);
    checks++;
    if (irq_num_o !== 5'd1 || irq_vec_o !== 32'h14) begin
      errors++; $display("FAIL prio_first num=%0d vec=%h exp 1,14", irq_num_o, irq_vec_o);
    end
    do_ack(8'hFD);
    irq_i = 8'h08;
    step(); step();
    do_eoi();
    wait_req(10);
    checks++;
    if (irq_num_o !== 5'd3 || irq_vec_o !== 32'h1C) begin
      errors++; $display("FAIL prio_second num=%0d vec=%h exp 3,1c", irq_num_o, irq_vec_o);
    end
    do_ack(8'hF7);
    irq_i = 8'h00;
    step(); step();
    do_eoi();
    bus_write(4'h0, 32'h0);
  endtask

  task automatic test_ignore();
    eoi_i = 1'b1; irq_ack_i = 1'b1;
    step();
    eoi_i = 1'b0; irq_ack_i = 1'b0;
    checks++;
    if (eoi_o !== 8'hFF || irq_req_o !== 1'b0) begin
      errors++; $display("FAIL ignore_idle eoi=%h req=%b exp ff,0", eoi_o, irq_req_o);
    end
    bus_write(4'h0, 32'h20);
    irq_i = 8'h20;
    wait_req(10);
    eoi_i = 1'b1;
    step();
    eoi_i = 1'b0;
    checks++;
    if (irq_req_o !== 1'b1 || eoi_o !== 8'hFF || irq_num_o !== 5'd5) begin
      errors++; $display("FAIL ignore_request req=%b eoi=%h num=%0d exp 1,ff,5", irq_req_o, eoi_o, irq_num_o);
    end
    do_ack(8'hDF);
    irq_i = 8'h00;
    step(); step();
    do_eoi();
    bus_write(4'h0, 32'h0);
  endtask

  task automatic test_disable();
    logic [31:0] d;
    bus_write(4'h0, 32'h10);
    irq_i = 8'h10;
    wait_req(10);
    checks++;
    if (irq_num_o !== 5'd4) begin errors++; $display("FAIL disable_num got=%0d exp=4", irq_num_o); end
    bus_write(4'h0, 32'h0);
    checks++;
    if (irq_req_o !== 1'b0 || eoi_o !== 8'hFF) begin
      errors++; $display("FAIL disable_drop req=%b eoi=%h exp 0,ff", irq_req_o, eoi_o);
    end
    bus_read(4'hC, d);
    checks++;
    if (d[31] !== 1'b0) begin errors++; $display("FAIL disable_idle status=%h exp busy=0", d); end
    bus_write(4'h0, 32'h10);
    wait_req(10);
    sel_i = 1'b1; we_i = 1'b1; addr_i = 4'h0; data_i = 32'h0;
    step();
    sel_i = 1'b0; we_i = 1'b0;
    do_ack(8'hEF);
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h8000_0004) begin errors++; $display("FAIL ack_wins_status got=%h exp=80000004", d); end
    irq_i = 8'h00;
    step(); step();
    do_eoi();
  endtask

  task automatic test_ce();
    bus_write(4'h0, 32'h01);
    ce_i = 1'b0;
    irq_i = 8'h01;
    repeat (5) step();
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL ce_freeze req=%b exp=0", irq_req_o); end
    ce_i = 1'b1;
    step(); step(); step();
    checks++;
    if (irq_req_o !== 1'b1 || irq_num_o !== 5'd0 || irq_vec_o !== 32'h10) begin
      errors++; $display("FAIL ce_resume req=%b num=%0d vec=%h exp 1,0,10", irq_req_o, irq_num_o, irq_vec_o);
    end
    do_ack(8'hFE);
    irq_i = 8'h00;
    step(); step();
    do_eoi();
    bus_write(4'h0, 32'h0);
  endtask

  task automatic test_mode();
    logic [31:0] d;
`ifdef IRQ_CTRL_EDGE_EN
    bus_write(4'h8, 32'h01);
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h01) begin errors++; $display("FAIL mode_rw got=%h exp=1", d); end
    irq_i = 8'h01; step(); step(); irq_i = 8'h00;
    repeat (4) step();
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h01) begin errors++; $display("FAIL edge_latched got=%h exp=1", d); end
    bus_write(4'h4, 32'h01);
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL edge_w1c got=%h exp=0", d); end
    bus_write(4'h0, 32'h01);
    repeat (4) step();
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL edge_no_req got=%b exp=0", irq_req_o); end
    irq_i = 8'h01; step(); step(); irq_i = 8'h00;
    wait_req(10);
    do_ack(8'hFE);
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL edge_ack_clear got=%h exp=0", d); end
    do_eoi();
    bus_write(4'h8, 32'h0);
    bus_write(4'h0, 32'h0);
`else
    bus_write(4'h8, 32'hFF);
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mode_absent got=%h exp=0", d); end
    irq_i = 8'h01;
    step(); step();
    bus_write(4'h4, 32'h01);
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h01) begin errors++; $display("FAIL level_pending got=%h exp=1", d); end
    irq_i = 8'h00;
    step(); step();
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(4'h0, 32'h40);
    irq_i = 8'h40;
    wait_req(10);
    checks++;
    if (irq_num_o !== 5'd6) begin errors++; $display("FAIL rst_mid_num got=%0d exp=6", irq_num_o); end
    do_ack(8'hBF);
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if (eoi_o !== 8'hFF || irq_req_o !== 1'b0 || irq_vec_o !== 32'h10) begin
      errors++; $display("FAIL rst_async eoi=%h req=%b vec=%h exp ff,0,10", eoi_o, irq_req_o, irq_vec_o);
    end
    step(); step();
    reset_n_i = 1'b1;
    repeat (4) step();
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL rst_no_req got=%b exp=0", irq_req_o); end
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_enable got=%h exp=0", d); end
    irq_i = 8'h00;
  endtask

  initial begin
    reset_n_i = 1'b0; ce_i = 1'b1; irq_i = '0; irq_ack_i = 1'b0; eoi_i = 1'b0;
    sel_i = 1'b0; addr_i = '0; we_i = 1'b0; data_i = '0;
    step(); step();
    reset_n_i = 1'b1;
    step();
    test_reset();
    test_reg_width();
    test_basic();
    test_priority();
    test_ignore();
    test_disable();
    test_ce();
    test_mode();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
